// File: rtl/fsm_equiv_monitor.sv
// Equivalence monitor for a dual-implementation FSM: samples both outputs and the
// difference flag over a fixed window, then latches a sticky pass/fail verdict.
module fsm_equiv_monitor #(
  parameter int CNT_W       = 16,
  parameter int PASS_CYCLES = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_s,
  input  logic             in_b,
  input  logic             in_diff,
  output logic             busy,
  output logic             pass,
  output logic             fail,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] first_err_cycle,
  output logic             first_err_s,
  output logic             first_err_b,
  output logic             diff_bad
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    DONE_PASS = 2'd2,
    DONE_FAIL = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PASS_CYCLES - 1);

  state_t           state_q;
  logic             busy_q;
  logic             pass_q;
  logic             fail_q;
  logic [CNT_W-1:0] err_count_q;
  logic [CNT_W-1:0] cycle_count_q;
  logic [CNT_W-1:0] first_err_cycle_q;
  logic             first_err_s_q;
  logic             first_err_b_q;
  logic             diff_bad_q;

  logic             mismatch;
  logic             dbad;
  logic             last_sample;
  logic             clean_window;
  logic [CNT_W-1:0] err_count_d;
  logic [CNT_W-1:0] cycle_count_d;

  assign mismatch      = in_s ^ in_b;
  assign dbad          = in_diff ^ mismatch;
  assign last_sample   = (cycle_count_q == LAST_IDX);
  assign cycle_count_d = cycle_count_q + 1'b1;
  // Saturating error count; it can never exceed the window length in practice.
  assign err_count_d   = (mismatch && err_count_q != CNT_MAX) ? err_count_q + 1'b1
                                                              : err_count_q;
  // Verdict must fold in the final sample, which is not yet in the registers.
  assign clean_window  = (err_count_q == '0) && !mismatch && !diff_bad_q && !dbad;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= IDLE;
      busy_q            <= 1'b0;
      pass_q            <= 1'b0;
      fail_q            <= 1'b0;
      err_count_q       <= '0;
      cycle_count_q     <= '0;
      first_err_cycle_q <= '0;
      first_err_s_q     <= 1'b0;
      first_err_b_q     <= 1'b0;
      diff_bad_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE_PASS, DONE_FAIL: begin
          if (start) begin
            state_q           <= RUN;
            busy_q            <= 1'b1;
            pass_q            <= 1'b0;
            fail_q            <= 1'b0;
            err_count_q       <= '0;
            cycle_count_q     <= '0;
            first_err_cycle_q <= '0;
            first_err_s_q     <= 1'b0;
            first_err_b_q     <= 1'b0;
            diff_bad_q        <= 1'b0;
          end
        end
        RUN: begin
          cycle_count_q <= cycle_count_d;
          err_count_q   <= err_count_d;
          if (mismatch && err_count_q == '0) begin
            first_err_cycle_q <= cycle_count_q;
            first_err_s_q     <= in_s;
            first_err_b_q     <= in_b;
          end
          if (dbad) begin
            diff_bad_q <= 1'b1;
          end
          if (last_sample) begin
            busy_q <= 1'b0;
            if (clean_window) begin
              state_q <= DONE_PASS;
              pass_q  <= 1'b1;
            end else begin
              state_q <= DONE_FAIL;
              fail_q  <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy            = busy_q;
  assign pass            = pass_q;
  assign fail            = fail_q;
  assign err_count       = err_count_q;
  assign cycle_count     = cycle_count_q;
  assign first_err_cycle = first_err_cycle_q;
  assign first_err_s     = first_err_s_q;
  assign first_err_b     = first_err_b_q;
  assign diff_bad        = diff_bad_q;

endmodule

// File: tb/tb_fsm_equiv_monitor.sv
// Directed bench for fsm_equiv_monitor: table of 8-sample windows plus
// hand-written sequences for restart-while-running, asynchronous reset and hold.
module tb_fsm_equiv_monitor;
  localparam int CNT_W = 16;
  localparam int PC    = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             in_s;
  logic             in_b;
  logic             in_diff;
  logic             busy;
  logic             pass;
  logic             fail;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] cycle_count;
  logic [CNT_W-1:0] first_err_cycle;
  logic             first_err_s;
  logic             first_err_b;
  logic             diff_bad;

  int checks = 0;
  int errors = 0;

  fsm_equiv_monitor #(.CNT_W(CNT_W), .PASS_CYCLES(PC)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .in_s            (in_s),
    .in_b            (in_b),
    .in_diff         (in_diff),
    .busy            (busy),
    .pass            (pass),
    .fail            (fail),
    .err_count       (err_count),
    .cycle_count     (cycle_count),
    .first_err_cycle (first_err_cycle),
    .first_err_s     (first_err_s),
    .first_err_b     (first_err_b),
    .diff_bad        (diff_bad)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] s;
    logic [7:0] b;
    logic [7:0] d;
    logic       e_pass;
    logic       e_fail;
    int         e_err;
    int         e_fec;
    logic       e_fes;
    logic       e_feb;
    logic       e_db;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " busy"}, int'(busy), 0);
    chk({tag, " pass"}, int'(pass), 0);
    chk({tag, " fail"}, int'(fail), 0);
    chk({tag, " err_count"}, int'(err_count), 0);
    chk({tag, " cycle_count"}, int'(cycle_count), 0);
    chk({tag, " first_err"}, int'({first_err_cycle, first_err_s, first_err_b}), 0);
    chk({tag, " diff_bad"}, int'(diff_bad), 0);
  endtask

  // Start edge: inputs held neutral, then confirm everything cleared and busy up.
  task automatic start_window(input string tag);
    start = 1'b1; in_s = 1'b0; in_b = 1'b0; in_diff = 1'b0;
    tick();
    start = 1'b0;
    chk({tag, " busy after start"}, int'(busy), 1);
    chk({tag, " pass cleared"}, int'(pass), 0);
    chk({tag, " fail cleared"}, int'(fail), 0);
    chk({tag, " err cleared"}, int'(err_count), 0);
    chk({tag, " cycle cleared"}, int'(cycle_count), 0);
    chk({tag, " diff_bad cleared"}, int'(diff_bad), 0);
  endtask

  task automatic drive_sample(input logic s, input logic b, input logic d);
    in_s = s; in_b = b; in_diff = d;
    tick();
  endtask

  initial begin
    vecs[0] = '{s:8'hFF, b:8'hFF, d:8'h00, e_pass:1, e_fail:0, e_err:0, e_fec:0, e_fes:0, e_feb:0, e_db:0};
    vecs[1] = '{s:8'hFF, b:8'hD7, d:8'h28, e_pass:0, e_fail:1, e_err:2, e_fec:3, e_fes:1, e_feb:0, e_db:0};
    vecs[2] = '{s:8'h00, b:8'h00, d:8'h40, e_pass:0, e_fail:1, e_err:0, e_fec:0, e_fes:0, e_feb:0, e_db:1};
    vecs[3] = '{s:8'h80, b:8'h00, d:8'h80, e_pass:0, e_fail:1, e_err:1, e_fec:7, e_fes:1, e_feb:0, e_db:0};
    vecs[4] = '{s:8'h00, b:8'h01, d:8'h00, e_pass:0, e_fail:1, e_err:1, e_fec:0, e_fes:0, e_feb:1, e_db:1};
    vecs[5] = '{s:8'h0F, b:8'hF0, d:8'hFF, e_pass:0, e_fail:1, e_err:8, e_fec:0, e_fes:1, e_feb:0, e_db:0};

    rst = 1'b1; start = 1'b0; in_s = 1'b0; in_b = 1'b0; in_diff = 1'b0;
    #12;
    check_all_zero("reset");
    rst = 1'b0;

    for (int v = 0; v < 6; v++) begin
      int busy_edges;
      busy_edges = 0;
      start_window($sformatf("vec%0d", v));
      if (busy) busy_edges++;
      for (int i = 0; i < PC; i++) begin
        drive_sample(vecs[v].s[i], vecs[v].b[i], vecs[v].d[i]);
        if (busy) busy_edges++;
      end
      $display("window %0d: pass=%0b fail=%0b err=%0d cyc=%0d fec=%0d fes=%0b feb=%0b diff_bad=%0b",
               v, pass, fail, err_count, cycle_count, first_err_cycle, first_err_s, first_err_b, diff_bad);
      chk($sformatf("vec%0d busy_edges", v), busy_edges, PC);
      chk($sformatf("vec%0d pass", v), int'(pass), int'(vecs[v].e_pass));
      chk($sformatf("vec%0d fail", v), int'(fail), int'(vecs[v].e_fail));
      chk($sformatf("vec%0d err_count", v), int'(err_count), vecs[v].e_err);
      chk($sformatf("vec%0d cycle_count", v), int'(cycle_count), PC);
      chk($sformatf("vec%0d first_err_cycle", v), int'(first_err_cycle), vecs[v].e_fec);
      chk($sformatf("vec%0d first_err_s", v), int'(first_err_s), int'(vecs[v].e_fes));
      chk($sformatf("vec%0d first_err_b", v), int'(first_err_b), int'(vecs[v].e_feb));
      chk($sformatf("vec%0d diff_bad", v), int'(diff_bad), int'(vecs[v].e_db));
    end

    // Hold in DONE_FAIL: inputs toggling without start must not disturb anything.
    for (int i = 0; i < 3; i++) drive_sample(1'b1, 1'b0, 1'b0);
    $display("hold: pass=%0b fail=%0b err=%0d cyc=%0d", pass, fail, err_count, cycle_count);
    chk("hold fail", int'(fail), 1);
    chk("hold err_count", int'(err_count), 8);
    chk("hold cycle_count", int'(cycle_count), PC);
    chk("hold busy", int'(busy), 0);

    // start pulsed on sample 4 of a running window is ignored.
    start_window("restart");
    for (int i = 0; i < PC; i++) begin
      start = (i == 4);
      drive_sample(1'b1, 1'b1, 1'b0);
      if (i == 4) begin
        chk("restart cycle after ignored start", int'(cycle_count), 5);
        chk("restart busy after ignored start", int'(busy), 1);
      end
      if (i == PC - 2) chk("restart busy before last", int'(busy), 1);
    end
    start = 1'b0;
    $display("restart: pass=%0b fail=%0b cyc=%0d busy=%0b", pass, fail, cycle_count, busy);
    chk("restart pass", int'(pass), 1);
    chk("restart fail", int'(fail), 0);
    chk("restart cycle_count", int'(cycle_count), PC);
    chk("restart busy", int'(busy), 0);

    // Asynchronous reset mid-window, between clock edges, then a fresh full window.
    start_window("rstmid");
    for (int i = 0; i < 5; i++) drive_sample(1'b1, 1'b0, 1'b1);
    #2 rst = 1'b1;
    #1;
    $display("async reset: busy=%0b err=%0d cyc=%0d", busy, err_count, cycle_count);
    check_all_zero("async reset");
    @(negedge clk);
    rst = 1'b0;
    start_window("post-reset");
    for (int i = 0; i < PC; i++) drive_sample(1'b0, 1'b0, 1'b0);
    $display("post-reset: pass=%0b fail=%0b cyc=%0d", pass, fail, cycle_count);
    chk("post-reset pass", int'(pass), 1);
    chk("post-reset fail", int'(fail), 0);
    chk("post-reset cycle_count", int'(cycle_count), PC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog: the directed sequence is short, so anything this long is a hang.
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
